// File: rtl/pic_inta_sequencer.sv
// 8259A interrupt-acknowledge sequencer (8086 mode): drives INT, freezes the
// priority path across both INTA pulses, sets ISR, drives CAS and the vector.
module pic_inta_sequencer #(
  parameter int unsigned INTA_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INTA,
  input  logic       INT_request,
  input  logic [2:0] int_level,
  input  logic [4:0] icw2_base,
  input  logic       aeoi,
  input  logic       single_mode,
  input  logic       is_master,
  input  logic [7:0] slave_mask,
  input  logic [2:0] slave_id,
  input  logic [2:0] cas_in,
  output logic       INT,
  output logic       freezing,
  output logic       isr_set,
  output logic       eoi_pulse,
  output logic [2:0] isr_level,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       timeout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTA_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACK1,
    S_WAIT2,
    S_ACK2
  } state_t;

  state_t           state_q;
  logic             inta_q;
  logic [CNT_W-1:0] cnt_q;
  logic             spur_q;
  logic             sel_q;
  logic             int_q;
  logic             freeze_q;
  logic             isr_set_q;
  logic             eoi_q;
  logic [2:0]       lvl_q;
  logic [2:0]       cas_out_q;
  logic             cas_oe_q;
  logic [7:0]       data_out_q;
  logic             data_oe_q;
  logic             timeout_q;

  logic fall_c;
  logic rise_c;
  logic casc_c;

  assign fall_c = inta_q & ~INTA;
  assign rise_c = ~inta_q & INTA;
  // Master routes the vector to a slave only for a genuine request on a slave input
  assign casc_c = ~single_mode & slave_mask[int_level] & INT_request;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      inta_q     <= 1'b1;
      cnt_q      <= '0;
      spur_q     <= 1'b0;
      sel_q      <= 1'b0;
      int_q      <= 1'b0;
      freeze_q   <= 1'b0;
      isr_set_q  <= 1'b0;
      eoi_q      <= 1'b0;
      lvl_q      <= 3'd0;
      cas_out_q  <= 3'd0;
      cas_oe_q   <= 1'b0;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      inta_q    <= INTA;
      isr_set_q <= 1'b0;
      eoi_q     <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (INT_request) begin
            int_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (fall_c) begin
            int_q     <= 1'b0;
            freeze_q  <= 1'b1;
            spur_q    <= ~INT_request;
            lvl_q     <= INT_request ? int_level : 3'd7;
            isr_set_q <= INT_request;
            if (is_master && casc_c) begin
              cas_out_q <= int_level;
              cas_oe_q  <= 1'b1;
              sel_q     <= 1'b0;
            end else begin
              sel_q <= is_master;
            end
            state_q <= S_ACK1;
          end
        end
        S_ACK1: begin
          if (rise_c) begin
            cnt_q <= '0;
            // A slave learns whether it owns the vector from CAS during the first pulse
            if (!is_master) begin
              sel_q <= (cas_in == slave_id) | single_mode;
            end
            state_q <= S_WAIT2;
          end
        end
        S_WAIT2: begin
          if (fall_c) begin
            data_out_q <= {icw2_base, lvl_q};
            data_oe_q  <= sel_q;
            state_q    <= S_ACK2;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            freeze_q  <= 1'b0;
            cas_oe_q  <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_ACK2: begin
          if (rise_c) begin
            data_oe_q <= 1'b0;
            cas_oe_q  <= 1'b0;
            freeze_q  <= 1'b0;
            eoi_q     <= aeoi & ~spur_q;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign INT       = int_q;
  assign freezing  = freeze_q;
  assign isr_set   = isr_set_q;
  assign eoi_pulse = eoi_q;
  assign isr_level = lvl_q;
  assign cas_out   = cas_out_q;
  assign cas_oe    = cas_oe_q;
  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign timeout   = timeout_q;

endmodule
